uart_mmio_controller: RTL and testbench



---
 rtl/uart_mmio_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_mmio_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_controller.sv
// Memory-mapped UART controller for the SingleCycleCPU peripheral bus.
// Register map: 0=TXD, 1=RXD, 2=CON, 3=reserved.
// Bit timing is fixed by BIT_CYCLES, which is 100 MHz / 9600 baud by default.
module uart_mmio_controller #(
  parameter int unsigned BIT_CYCLES  = 10417,
  parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        UART_RX,
  output logic        UART_TX,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Bus decode
  logic txd_wr, con_wr, rxd_rd, con_rd;
  assign txd_wr = wr && (addr == 2'd0);
  assign con_wr = wr && (addr == 2'd2);
  assign rxd_rd = rd && (addr == 2'd1);
  assign con_rd = rd && (addr == 2'd2);

  // Control/status state
  logic       tx_irq_en, rx_irq_en;
  logic       tx_done, rx_valid, overrun, frame_err;
  logic [7:0] rx_data;
  logic [7:0] tx_hold;

  // ---------------------------------------------------------------- RX
  logic             rx_meta, rx_sync;
  rx_state_t        rx_state, rx_state_d;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shreg;
  logic             rx_tick, rx_half;
  logic             rx_run, rx_cnt_clr, rx_shift, rx_ok, rx_bad;

  assign rx_tick = (rx_cnt == BIT_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
    end
  end

  // RX state register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_d;
  end

  // RX next-state logic
  always_comb begin
    rx_state_d = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_state_d = RX_START;
      RX_START: if (rx_half) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_d = rx_sync ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_sync) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // RX strobes derived from state and counter
  always_comb begin
    rx_run     = (rx_state == RX_START) || (rx_state == RX_DATA) || (rx_state == RX_STOP);
    rx_cnt_clr = (rx_state_d != rx_state) || rx_tick;
    rx_shift   = (rx_state == RX_DATA) && rx_tick;
    rx_ok      = (rx_state == RX_STOP) && rx_tick && rx_sync;
    rx_bad     = (rx_state == RX_STOP) && rx_tick && !rx_sync;
  end

  // RX bit-timing counter and LSB-first shift register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      if (rx_cnt_clr)  rx_cnt <= '0;
      else if (rx_run) rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_IDLE) rx_bit <= '0;
      else if (rx_shift)       rx_bit <= rx_bit + 3'd1;
      if (rx_shift) rx_shreg <= {rx_sync, rx_shreg[7:1]};
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_t        tx_state, tx_state_d;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shreg;
  logic             tx_line;
  logic             tx_tick, tx_accept;
  logic             tx_run, tx_cnt_clr, tx_fin, tx_busy;

  assign tx_tick   = (tx_cnt == BIT_LAST);
  assign tx_accept = txd_wr && (tx_state == TX_IDLE);

  // TX state register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_d;
  end

  // TX next-state logic
  always_comb begin
    tx_state_d = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (tx_accept) tx_state_d = TX_START;
      TX_START: if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // TX strobes derived from state and counter
  always_comb begin
    tx_busy    = (tx_state != TX_IDLE);
    tx_run     = tx_busy;
    tx_cnt_clr = (tx_state_d != tx_state) || tx_tick;
    tx_fin     = (tx_state == TX_STOP) && tx_tick;
  end

  // TX datapath; the line is registered and updated together with the state
  // change, so the serial output is glitch-free and each bit is exactly BIT_CYCLES.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_hold  <= '0;
      tx_line  <= 1'b1;
    end else begin
      if (tx_cnt_clr)  tx_cnt <= '0;
      else if (tx_run) tx_cnt <= tx_cnt + 1'b1;
      if (tx_accept) begin
        tx_hold  <= wdata;
        tx_shreg <= wdata;
        tx_bit   <= '0;
        tx_line  <= 1'b0;
      end else if ((tx_state == TX_START) && tx_tick) begin
        tx_line <= tx_shreg[0];
      end else if ((tx_state == TX_DATA) && tx_tick) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        tx_bit   <= tx_bit + 3'd1;
        tx_line  <= (tx_bit == 3'd7) ? 1'b1 : tx_shreg[1];
      end
    end
  end

  assign UART_TX = tx_line;

  // ---------------------------------------------------------------- CON / RXD
  // Status flags: a set event always wins over a clear-on-read in the same cycle
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      if (con_wr) begin
        tx_irq_en <= wdata[0];
        rx_irq_en <= wdata[1];
      end
      if (rx_ok) rx_data <= rx_shreg;

      if (tx_fin)      tx_done <= 1'b1;
      else if (con_rd) tx_done <= 1'b0;

      if (rx_ok)       rx_valid <= 1'b1;
      else if (rxd_rd) rx_valid <= 1'b0;

      // A byte arriving in the same cycle as the RXD read replaces data that was consumed
      if (rx_ok && rx_valid && !rxd_rd) overrun <= 1'b1;
      else if (con_rd)                  overrun <= 1'b0;

      if (rx_bad)      frame_err <= 1'b1;
      else if (con_rd) frame_err <= 1'b0;
    end
  end

  // Registered interrupt request
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (tx_irq_en && tx_done) || (rx_irq_en && rx_valid);
  end

  // Combinational read mux, zero-extended and forced to 0 when not reading
  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (addr)
        2'd0:    rdata[7:0] = tx_hold;
        2'd1:    rdata[7:0] = rx_data;
        2'd2:    rdata[6:0] = {frame_err, overrun, tx_busy, rx_valid, tx_done, rx_irq_en, tx_irq_en};
        default: rdata      = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_controller.sv
// Self-checking bench for uart_mmio_controller with a register-level reference model.
module tb_uart_mmio_controller;

  localparam int BIT = 16;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        UART_RX = 1'b1;
  logic        UART_TX;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [7:0]  wdata = 8'd0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model of the programmer-visible state
  bit       m_tx_en, m_rx_en, m_tx_done, m_rx_valid, m_overrun, m_frame_err;
  bit [7:0] m_rx_data, m_tx_hold;

  uart_mmio_controller #(.BIT_CYCLES(BIT)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .UART_RX(UART_RX),
    .UART_TX(UART_TX),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] con_exp(input bit busy);
    return {25'd0, m_frame_err, m_overrun, busy, m_rx_valid, m_tx_done, m_rx_en, m_tx_en};
  endfunction

  task automatic model_reset();
    m_tx_en = 0; m_rx_en = 0; m_tx_done = 0; m_rx_valid = 0;
    m_overrun = 0; m_frame_err = 0; m_rx_data = 0; m_tx_hold = 0;
  endtask

  task automatic model_read_side_effects(input logic [1:0] a);
    if (a == 2'd1) m_rx_valid = 0;
    if (a == 2'd2) begin
      m_tx_done = 0; m_overrun = 0; m_frame_err = 0;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge sysclk);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge sysclk);
    rd = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge sysclk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge sysclk);
    wr = 1'b0;
    if (a == 2'd2) begin
      m_tx_en = d[0]; m_rx_en = d[1];
    end
  endtask

  // Read a register while the transmitter is idle and compare with the model
  task automatic read_chk(input logic [1:0] a, input string tag);
    logic [31:0] exp, got;
    case (a)
      2'd0:    exp = {24'd0, m_tx_hold};
      2'd1:    exp = {24'd0, m_rx_data};
      2'd2:    exp = con_exp(1'b0);
      default: exp = 32'd0;
    endcase
    bus_read(a, got);
    check(tag, got, exp);
    model_read_side_effects(a);
  endtask

  // Serial frame into UART_RX; the model records what a receiver must report
  task automatic uart_send(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RX = fr[i];
      repeat (BIT) @(negedge sysclk);
    end
    UART_RX = 1'b1;
    repeat (4) @(negedge sysclk);
    if (stop_ok) begin
      if (m_rx_valid) m_overrun = 1;
      m_rx_valid = 1;
      m_rx_data  = b;
    end else begin
      m_frame_err = 1;
    end
  endtask

  // Transmit b and check the line every cycle; optionally retry a write mid-frame
  task automatic tx_check(input logic [7:0] b, input bit try_second);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    bus_write(2'd0, b);
    m_tx_hold = b;
    for (int i = 0; i < 10 * BIT; i++) begin
      if (try_second && i == 40) begin
        wr = 1'b1; addr = 2'd0; wdata = ~b;
        #1 check("tx_line", UART_TX, fr[i / BIT]);
        @(negedge sysclk);
        wr = 1'b0;
      end else begin
        rd = 1'b1; addr = 2'd2;
        #1 check("tx_line", UART_TX, fr[i / BIT]);
        check("tx_busy", rdata[4], 1'b1);
        @(negedge sysclk);
      end
    end
    rd = 1'b0;
    m_tx_done = 0; m_overrun = 0; m_frame_err = 0;
    m_tx_done = 1;
    check("tx_idle_line", UART_TX, 1'b1);
    read_chk(2'd2, "tx_done_con");
    read_chk(2'd0, "txd_hold");
  endtask

  logic [31:0] d;
  logic [7:0]  rb;
  bit          found;
  bit          ok;

  initial begin
    model_reset();
    repeat (3) @(negedge sysclk);
    #1;
    check("rst_tx", UART_TX, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge sysclk);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);

    for (int a = 0; a < 4; a++) read_chk(2'(a), "rst_reg");
    bus_write(2'd3, 8'hFF);
    read_chk(2'd3, "reserved_rd");
    read_chk(2'd2, "reserved_wr_con");

    // Simultaneous read and write of CON: read shows the pre-write value
    @(negedge sysclk);
    rd = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 8'hFF;
    #1 check("rdwr_pre", rdata, con_exp(1'b0));
    @(negedge sysclk);
    rd = 1'b0; wr = 1'b0;
    m_tx_en = 1; m_rx_en = 1;
    model_read_side_effects(2'd2);
    read_chk(2'd2, "rdwr_post");
    bus_write(2'd2, 8'h00);

    // Test 1: receive 0x54
    uart_send(8'h54, 1'b1);
    read_chk(2'd2, "t1_con_valid");
    read_chk(2'd1, "t1_rxd");
    read_chk(2'd2, "t1_con_cleared");

    // Test 2: rx interrupt timing
    bus_write(2'd2, 8'h02);
    read_chk(2'd2, "t2_con");
    found = 0;
    fork
      uart_send(8'h0C, 1'b1);
      begin
        rd = 1'b1; addr = 2'd2;
        for (int i = 0; i < 12 * BIT && !found; i++) begin
          @(negedge sysclk);
          #1;
          if (rdata[3]) begin
            found = 1;
            check("t2_irq_lag", irq, 1'b0);
            @(negedge sysclk);
            #1 check("t2_irq_set", irq, 1'b1);
          end
        end
        rd = 1'b0;
        check("t2_valid_seen", found, 1'b1);
      end
    join
    read_chk(2'd1, "t2_rxd");
    check("t2_irq_hold", irq, 1'b1);
    @(negedge sysclk);
    check("t2_irq_clear", irq, 1'b0);
    bus_write(2'd2, 8'h00);

    // Test 3: transmit 0x0C with an ignored write while busy
    tx_check(8'h0C, 1'b1);

    // Test 4: overrun
    uart_send(8'h54, 1'b1);
    uart_send(8'h0C, 1'b1);
    read_chk(2'd1, "t4_rxd");
    read_chk(2'd2, "t4_con_overrun");
    read_chk(2'd2, "t4_con_cleared");

    // Test 5: frame error, then a short glitch on an idle line
    uart_send(8'h3C, 1'b0);
    read_chk(2'd2, "t5_frame_err");
    read_chk(2'd2, "t5_fe_cleared");
    UART_RX = 1'b0;
    repeat (3) @(negedge sysclk);
    UART_RX = 1'b1;
    repeat (3 * BIT) @(negedge sysclk);
    read_chk(2'd2, "t5_glitch_con");
    read_chk(2'd1, "t5_glitch_rxd");

    // Randomized receive traffic with optional reads in between
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      uart_send(rb, ok);
      if ($urandom_range(0, 1) == 1) read_chk(2'd1, "rnd_rxd");
      read_chk(2'd2, "rnd_con");
    end
    read_chk(2'd1, "rnd_rxd_final");

    // Randomized transmit traffic with tx interrupt enabled
    bus_write(2'd2, 8'h01);
    for (int k = 0; k < 2; k++) begin
      rb = 8'($urandom);
      tx_check(rb, k[0]);
    end
    bus_write(2'd2, 8'h00);

    // Test 6: asynchronous reset during data bit 3 of 0xA5 (bit 3 = 0)
    bus_write(2'd0, 8'hA5);
    repeat (4 * BIT + 8) @(negedge sysclk);
    #1 check("t6_bit3_low", UART_TX, 1'b0);
    #2 reset = 1'b0;
    #1 check("t6_async_tx", UART_TX, 1'b1);
    check("t6_irq", irq, 1'b0);
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
    model_reset();
    read_chk(2'd2, "t6_con_zero");
    read_chk(2'd0, "t6_txd_zero");
    read_chk(2'd1, "t6_rxd_zero");
    tx_check(8'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
